sum_accumulator: RTL

//   Downstream consumer of the 8-bit ripple adder's sum output. Accepts a stream of

---
 rtl/sum_accumulator.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sum_accumulator.sv
// sum_accumulator
//   Collects COUNT consecutive unsigned samples from the adder's sum output,
//   delivered over a valid/ready handshake, and adds them into a wider running
//   total. The saturated block total and a saturation flag are then offered on
//   a second valid/ready handshake. The block does not accept new samples while
//   a result is waiting to be taken.
//
// Parameters
//   WIDTH      width of incoming samples
//   ACC_WIDTH  width of accumulator and out_total (must be > WIDTH)
//   COUNT      samples per block (>= 1)
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous reset, active low (priority over clear)
//   in_sum        incoming sample, unsigned
//   in_valid      in_sum is valid this cycle
//   in_ready      block accepts a sample this cycle
//   clear         synchronous abort of the current block / held result
//   out_total     saturated block total
//   out_overflow  block total saturated
//   out_valid     out_total / out_overflow are valid
//   out_ready     consumer takes the result
module sum_accumulator #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int COUNT     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_sum,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 clear,
    output logic [ACC_WIDTH-1:0] out_total,
    output logic                 out_overflow,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // A 1-bit counter is kept even for COUNT=1 so the vector is never empty.
    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]     cnt;
    logic                 sat;

    logic                 take;       // sample handshake this cycle
    logic                 last;       // the sample being taken closes the block
    logic [ACC_WIDTH:0]   sum_wide;   // one extra bit exposes the carry out
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 sat_next;

    // ------------------------------------------------------------------
    // Datapath arithmetic
    // ------------------------------------------------------------------
    assign take = in_valid && in_ready;
    assign last = (cnt == LAST_CNT);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        sum_wide = {1'b0, acc} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, in_sum};
        acc_next = sum_wide[ACC_WIDTH-1:0];
        sat_next = sat;
        if (sum_wide[ACC_WIDTH]) begin
            // Once pinned at all ones, adding anything keeps it there.
            acc_next = {ACC_WIDTH{1'b1}};
            sat_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic (clear overrides both handshakes)
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (take && last) next_state = HOLD;
                HOLD:    if (out_ready)    next_state = ACCUM;
                default: next_state = ACCUM;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from the registered state
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state == ACCUM) && !clear;
        out_valid = (state == HOLD);
    end

    // ------------------------------------------------------------------
    // Accumulator, counter, saturation flag and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            acc          <= '0;
            cnt          <= '0;
            sat          <= 1'b0;
            out_total    <= '0;
            out_overflow <= 1'b0;
        end else if (clear) begin
            // Result registers keep their values; out_valid drops with the
            // state, so their contents are meaningless until the next block.
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (take) begin
                        if (last) begin
                            out_total    <= acc_next;
                            out_overflow <= sat_next;
                        end else begin
                            acc <= acc_next;
                            cnt <= cnt + 1'b1;
                            sat <= sat_next;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        acc <= '0;
                        cnt <= '0;
                        sat <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
